rf_cmd_ctrl: RTL and testbench

Command-frame controller directly upstream of the register file. It consumes bytes from the UART-RX synchroniser (rx_data/rx_valid) and decodes register write and read frames. It drives the RF wren/rden/address/wrdata strobes, captures RF read data, and pushes it as one byte toward the TX FIFO. A per-frame inter-byte timeout keeps the FSM from hanging on truncated frames.

---
 rtl/rf_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rf_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_cmd_ctrl.sv
// rf_cmd_ctrl: decodes UART command frames into register-file writes and reads.
// Write frame {WR_CMD, addr, data}, read frame {RD_CMD, addr}. Read data is
// pushed as a single byte toward the TX FIFO. An inter-byte timeout aborts
// truncated frames so the controller can never wedge mid-frame.
module rf_cmd_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB,
    parameter int                    TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rf_wren,
    output logic                  rf_rden,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_wrdata,
    input  logic [DATA_WIDTH-1:0] rf_rddata,
    input  logic                  rf_rddata_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_full,
    output logic                  busy,
    output logic                  frame_err
);

    localparam int              CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO_MAX = CW'(TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_WR_EXEC = 3'd3;
    localparam logic [2:0] S_RD_ADDR = 3'd4;
    localparam logic [2:0] S_RD_EXEC = 3'd5;
    localparam logic [2:0] S_RD_WAIT = 3'd6;
    localparam logic [2:0] S_TX_PUSH = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  err_d, tx_vld_d;
    logic                  wren_q, rden_q, tx_vld_q, err_q, busy_q;
    logic                  waiting;
    logic                  addr_ovf;

    // States that wait on the next byte of a frame are the only ones that time out
    assign waiting  = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) || (state_q == S_RD_ADDR);
    assign addr_ovf = (rx_data[DATA_WIDTH-1:ADDR_WIDTH] != '0);

    // Next-state decode, error detection and inter-byte timeout counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        txd_d    = txd_q;
        err_d    = 1'b0;
        tx_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == WR_CMD)      state_d = S_WR_ADDR;
                    else if (rx_data == RD_CMD) state_d = S_RD_ADDR;
                    else                        err_d   = 1'b1;
                end
            end
            S_WR_ADDR, S_RD_ADDR: begin
                if (rx_valid) begin
                    addr_d = rx_data[ADDR_WIDTH-1:0];
                    if (addr_ovf) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = (state_q == S_WR_ADDR) ? S_WR_DATA : S_RD_EXEC;
                    end
                end else if (cnt_q == TO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (rx_valid) begin
                    data_d  = rx_data;
                    state_d = S_WR_EXEC;
                end else if (cnt_q == TO_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR_EXEC: begin
                err_d   = rx_valid;
                state_d = S_IDLE;
            end
            S_RD_EXEC: begin
                err_d   = rx_valid;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // RF latency is fixed; the valid flag only qualifies this sample
                txd_d = rf_rddata;
                if (rf_rddata_valid) begin
                    err_d   = rx_valid;
                    state_d = S_TX_PUSH;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TX_PUSH: begin
                // No timeout here: backpressure may last indefinitely
                err_d = rx_valid;
                if (!tx_full) begin
                    tx_vld_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d != state_q) || rx_valid) cnt_d = '0;
        else if (waiting && (cnt_q != TO_MAX)) cnt_d = cnt_q + 1'b1;
    end

    // State, holding registers and one-cycle strobes, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            txd_q    <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            tx_vld_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            txd_q    <= txd_d;
            wren_q   <= (state_d == S_WR_EXEC);
            rden_q   <= (state_d == S_RD_EXEC);
            tx_vld_q <= tx_vld_d;
            err_q    <= err_d;
            busy_q   <= (state_d != S_IDLE);
        end
    end

    assign rf_wren    = wren_q;
    assign rf_rden    = rden_q;
    assign rf_address = addr_q;
    assign rf_wrdata  = data_q;
    assign tx_data    = txd_q;
    assign tx_valid   = tx_vld_q;
    assign busy       = busy_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_rf_cmd_ctrl.sv
// Bench for rf_cmd_ctrl: directed frames from the test plan plus randomized
// frames, checked against a frame-level reference (register array, expected
// write/TX lists and an expected frame-error count).
module tb_rf_cmd_ctrl;

    localparam int TO = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rf_wren, rf_rden;
    logic [3:0] rf_address;
    logic [7:0] rf_wrdata;
    logic [7:0] rf_rddata;
    logic       rf_rddata_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_full;
    logic       busy;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    rf_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_wren(rf_wren), .rf_rden(rf_rden), .rf_address(rf_address), .rf_wrdata(rf_wrdata),
        .rf_rddata(rf_rddata), .rf_rddata_valid(rf_rddata_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_full(tx_full),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Register file stand-in: one-cycle read latency, reset contents 01,41,81,C1,...
    logic [7:0] rf_mem [16] = '{8'h01, 8'h41, 8'h81, 8'hC1, 8'h01, 8'h41, 8'h81, 8'hC1,
                                8'h01, 8'h41, 8'h81, 8'hC1, 8'h01, 8'h41, 8'h81, 8'hC1};
    logic       rv_en = 1'b1;
    always @(posedge clk) begin
        if (rf_wren) rf_mem[rf_address] <= rf_wrdata;
        if (rf_rden) rf_rddata <= rf_mem[rf_address];
        rf_rddata_valid <= rv_en;
    end

    // Reference model state
    logic [7:0]  ref_mem [16] = '{8'h01, 8'h41, 8'h81, 8'hC1, 8'h01, 8'h41, 8'h81, 8'hC1,
                                  8'h01, 8'h41, 8'h81, 8'hC1, 8'h01, 8'h41, 8'h81, 8'hC1};
    logic [11:0] exp_wr[$], wr_seen[$];
    logic [7:0]  exp_tx[$], tx_seen[$];
    int          exp_err = 0, n_err = 0, n_both = 0;

    // Observed events
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) n_err++;
            if (rf_wren) wr_seen.push_back({rf_address, rf_wrdata});
            if (tx_valid) tx_seen.push_back(tx_data);
            if (rf_wren && rf_rden) n_both++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input int gap, input bit stray);
        send_byte(8'hAA);
        idle(gap);
        send_byte({4'h0, a});
        idle(gap);
        send_byte(d);
        chk("wr_wren", rf_wren, 1);
        chk("wr_addr", rf_address, a);
        chk("wr_data", rf_wrdata, d);
        ref_mem[a] = d;
        exp_wr.push_back({a, d});
        if (stray) begin
            send_byte(8'($urandom));
            exp_err++;
            chk("wr_stray_err", frame_err, 1);
        end else begin
            tick();
        end
        chk("wr_done_wren", rf_wren, 0);
        chk("wr_done_busy", busy, 0);
    endtask

    task automatic do_read(input logic [3:0] a, input int full, input bit vld, input bit stray);
        rv_en   = vld;
        tx_full = (full > 0);
        send_byte(8'hBB);
        send_byte({4'h0, a});
        chk("rd_rden", rf_rden, 1);
        chk("rd_addr", rf_address, a);
        tick();
        chk("rd_rden_off", rf_rden, 0);
        tick();
        rv_en = 1'b1;
        if (!vld) begin
            exp_err++;
            chk("rd_inval_err", frame_err, 1);
            chk("rd_inval_busy", busy, 0);
            tx_full = 1'b0;
        end else begin
            for (int i = 0; i < full; i++) begin
                if (stray && i == 0) begin
                    send_byte(8'($urandom));
                    exp_err++;
                    chk("rd_stray_err", frame_err, 1);
                end else begin
                    tick();
                end
                chk("rd_hold_txv", tx_valid, 0);
                chk("rd_hold_busy", busy, 1);
            end
            tx_full = 1'b0;
            tick();
            chk("rd_txv", tx_valid, 1);
            chk("rd_txd", tx_data, ref_mem[a]);
            chk("rd_done_busy", busy, 0);
            exp_tx.push_back(ref_mem[a]);
            tick();
            chk("rd_txv_off", tx_valid, 0);
        end
    endtask

    task automatic do_badop(input logic [7:0] b);
        send_byte(b);
        exp_err++;
        chk("badop_err", frame_err, 1);
        chk("badop_busy", busy, 0);
        tick();
        chk("badop_err_off", frame_err, 0);
    endtask

    task automatic do_badaddr(input logic [7:0] op, input logic [7:0] ab);
        send_byte(op);
        send_byte(ab);
        exp_err++;
        chk("badaddr_err", frame_err, 1);
        chk("badaddr_busy", busy, 0);
        chk("badaddr_wren", rf_wren | rf_rden, 0);
        tick();
        chk("badaddr_access", rf_wren | rf_rden, 0);
    endtask

    task automatic do_timeout(input logic [7:0] op, input bit with_addr, input logic [3:0] a);
        send_byte(op);
        if (with_addr) send_byte({4'h0, a});
        idle(TO);
        chk("to_early_err", frame_err, 0);
        chk("to_early_busy", busy, 1);
        tick();
        exp_err++;
        chk("to_err", frame_err, 1);
        chk("to_busy", busy, 0);
        tick();
        chk("to_err_off", frame_err, 0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_full  = 1'b0;
        idle(3);
        chk("reset_outs", {rf_wren, rf_rden, rf_address, rf_wrdata, tx_data, tx_valid, busy, frame_err}, 0);
        rst = 1'b0;
        tick();

        // Write then read back
        do_write(4'h5, 8'h3C, 0, 0);
        do_read(4'h5, 0, 1, 0);
        // Read under 20 cycles of backpressure, reg2 reset value 0x81
        do_read(4'h2, 20, 1, 0);
        // Illegal inputs
        do_badop(8'h55);
        do_badaddr(8'hAA, 8'h1F);
        do_badaddr(8'hBB, 8'hF0);
        // Timeouts, then a clean frame to the same address
        do_timeout(8'hAA, 1, 4'h3);
        do_write(4'h3, 8'h7E, 0, 0);
        do_read(4'h3, 0, 1, 0);
        do_timeout(8'hBB, 0, 4'h0);
        // Bytes spaced exactly at the timeout limit are still accepted
        do_write(4'h9, 8'hD5, TO, 0);

        // Reset mid-frame
        send_byte(8'hAA);
        send_byte(8'h04);
        rst = 1'b1;
        #1;
        chk("midrst_outs", {rf_wren, rf_rden, rf_address, rf_wrdata, tx_data, tx_valid, busy, frame_err}, 0);
        idle(2);
        chk("midrst_outs2", {rf_wren, rf_rden, rf_address, rf_wrdata, tx_data, tx_valid, busy, frame_err}, 0);
        rst = 1'b0;
        send_byte(8'h11);
        exp_err++;
        chk("midrst_badop", frame_err, 1);
        chk("midrst_nowr", wr_seen.size(), exp_wr.size());
        tick();

        // Back-to-back frames
        for (int n = 0; n < 4; n++) do_write(4'(n), 8'($urandom), 0, 0);
        for (int n = 0; n < 4; n++) do_read(4'(n), 0, 1, 0);

        // Randomized frames
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0, 1: do_write(4'($urandom), 8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
                2, 3: do_read(4'($urandom), $urandom_range(0, 5), ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0));
                4: begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    if (b == 8'hAA || b == 8'hBB) b = 8'h00;
                    do_badop(b);
                end
                default: do_badaddr(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB,
                                    {4'($urandom_range(1, 15)), 4'($urandom)});
            endcase
        end
        idle(2);

        chk("err_count", n_err, exp_err);
        chk("wr_count", wr_seen.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_seen.size(); i++)
            chk("wr_order", wr_seen[i], exp_wr[i]);
        chk("tx_count", tx_seen.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
            chk("tx_order", tx_seen[i], exp_tx[i]);
        chk("wren_rden_excl", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
